// File: rtl/predecode_register.sv
// ---------------------------------------------------------------------------
// predecode_register
//
// Opcode latch and interrupt injector feeding instruction_decode. On each
// accepted fetch it latches the opcode byte from the data bus. If a reset,
// NMI or IRQ is waiting, it latches BRK_OPCODE instead and holds the PC. A
// three-state sequencer (S_RESET / S_RUN / S_INT) tracks the interrupt
// sequence until the decoder reports that the vector load has finished.
//
// Ports
//   clk          system clock, rising edge
//   res          asynchronous reset, active-low
//   rdy          global ready; low freezes everything except NMI edge capture
//   data_bus_in  external data bus byte
//   fetch        opcode-fetch strobe from the decoder
//   int_done     decoder pulse: interrupt vector loaded
//   irq          interrupt request, active-low level
//   nmi          non-maskable interrupt, active-low, falling-edge
//   i_flag       interrupt-disable flag
//   instruction  opcode presented to the decoder
//   opcode_valid one-cycle pulse after each accepted load
//   pc_hold      high while the latched opcode is an injected BRK
//   int_active   high during the interrupt sequence
//   vector_sel   00 none, 01 NMI, 10 RES, 11 IRQ
// ---------------------------------------------------------------------------
module predecode_register #(
    parameter logic [7:0] BRK_OPCODE = 8'h00
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rdy,
    input  logic [7:0] data_bus_in,
    input  logic       fetch,
    input  logic       int_done,
    input  logic       irq,
    input  logic       nmi,
    input  logic       i_flag,
    output logic [7:0] instruction,
    output logic       opcode_valid,
    output logic       pc_hold,
    output logic       int_active,
    output logic [1:0] vector_sel
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_INT   = 2'd2
    } state_t;

    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_NMI  = 2'b01;
    localparam logic [1:0] VEC_RES  = 2'b10;
    localparam logic [1:0] VEC_IRQ  = 2'b11;

    state_t     state;
    state_t     state_next;
    state_t     eval_state;
    logic [7:0] instruction_next;
    logic       opcode_valid_next;
    logic       pc_hold_next;
    logic       int_active_next;
    logic [1:0] vector_sel_next;
    logic       nmi_prev;
    logic       nmi_pending;
    logic       nmi_pending_next;
    logic       nmi_taken;
    logic       nmi_edge;
    logic       irq_req;

    assign nmi_edge = nmi_prev & ~nmi;
    assign irq_req  = ~irq & ~i_flag;

    // A new edge always lands in pending; only the registered pending flag
    // is consumed by a fetch, so an edge on the fetch clock waits one fetch.
    assign nmi_pending_next = nmi_edge | (nmi_pending & ~nmi_taken);

    always_comb begin
        state_next        = state;
        eval_state        = state;
        instruction_next  = instruction;
        opcode_valid_next = 1'b0;
        pc_hold_next      = pc_hold;
        int_active_next   = int_active;
        vector_sel_next   = vector_sel;
        nmi_taken         = 1'b0;

        if (rdy) begin
            // int_done is retired first so a coincident fetch is judged
            // as if the sequencer were already back in S_RUN.
            if (state == S_INT && int_done) begin
                eval_state      = S_RUN;
                state_next      = S_RUN;
                int_active_next = 1'b0;
                vector_sel_next = VEC_NONE;
                pc_hold_next    = 1'b0;
            end

            if (fetch) begin
                case (eval_state)
                    S_RESET: begin
                        instruction_next  = BRK_OPCODE;
                        opcode_valid_next = 1'b1;
                        vector_sel_next   = VEC_RES;
                        pc_hold_next      = 1'b1;
                        int_active_next   = 1'b1;
                        state_next        = S_INT;
                    end
                    S_RUN: begin
                        opcode_valid_next = 1'b1;
                        if (nmi_pending) begin
                            instruction_next = BRK_OPCODE;
                            nmi_taken        = 1'b1;
                            vector_sel_next  = VEC_NMI;
                            pc_hold_next     = 1'b1;
                            int_active_next  = 1'b1;
                            state_next       = S_INT;
                        end else if (irq_req) begin
                            instruction_next = BRK_OPCODE;
                            vector_sel_next  = VEC_IRQ;
                            pc_hold_next     = 1'b1;
                            int_active_next  = 1'b1;
                            state_next       = S_INT;
                        end else begin
                            instruction_next = data_bus_in;
                            vector_sel_next  = VEC_NONE;
                            pc_hold_next     = 1'b0;
                        end
                    end
                    default: begin
                        // S_INT: fetches are ignored until int_done.
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= S_RESET;
            instruction  <= 8'h00;
            opcode_valid <= 1'b0;
            pc_hold      <= 1'b1;
            int_active   <= 1'b0;
            vector_sel   <= VEC_RES;
            nmi_prev     <= 1'b1;
            nmi_pending  <= 1'b0;
        end else begin
            state        <= state_next;
            instruction  <= instruction_next;
            opcode_valid <= opcode_valid_next;
            pc_hold      <= pc_hold_next;
            int_active   <= int_active_next;
            vector_sel   <= vector_sel_next;
            nmi_prev     <= nmi;
            nmi_pending  <= nmi_pending_next;
        end
    end

endmodule

// File: tb/tb_predecode_register.sv
module tb_predecode_register;

    logic       clk = 1'b0;
    logic       res;
    logic       rdy;
    logic [7:0] data_bus_in;
    logic       fetch;
    logic       int_done;
    logic       irq;
    logic       nmi;
    logic       i_flag;
    logic [7:0] instruction;
    logic       opcode_valid;
    logic       pc_hold;
    logic       int_active;
    logic [1:0] vector_sel;

    int checks   = 0;
    int failures = 0;

    predecode_register dut (
        .clk          (clk),
        .res          (res),
        .rdy          (rdy),
        .data_bus_in  (data_bus_in),
        .fetch        (fetch),
        .int_done     (int_done),
        .irq          (irq),
        .nmi          (nmi),
        .i_flag       (i_flag),
        .instruction  (instruction),
        .opcode_valid (opcode_valid),
        .pc_hold      (pc_hold),
        .int_active   (int_active),
        .vector_sel   (vector_sel)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Full output snapshot: instruction, opcode_valid, pc_hold, int_active, vector_sel.
    task automatic check_all(input string tag, input logic [7:0] ins, input logic ov,
                             input logic ph, input logic ia, input logic [1:0] vs);
        check({tag, ".instruction"}, instruction, ins);
        check({tag, ".opcode_valid"}, {7'd0, opcode_valid}, {7'd0, ov});
        check({tag, ".pc_hold"}, {7'd0, pc_hold}, {7'd0, ph});
        check({tag, ".int_active"}, {7'd0, int_active}, {7'd0, ia});
        check({tag, ".vector_sel"}, {6'd0, vector_sel}, {6'd0, vs});
    endtask

    initial begin
        res = 1'b0; rdy = 1'b1; data_bus_in = 8'hA9; fetch = 1'b0;
        int_done = 1'b0; irq = 1'b1; nmi = 1'b1; i_flag = 1'b0;
        tick(); tick();
        check_all("reset", 8'h00, 1'b0, 1'b1, 1'b0, 2'b10);

        // Reset release, first fetch injects reset BRK
        res = 1'b1;
        tick();
        fetch = 1'b1;
        tick();
        check_all("res_brk", 8'h00, 1'b1, 1'b1, 1'b1, 2'b10);
        fetch = 1'b0;
        tick();
        check("res_brk_valid_drop", {7'd0, opcode_valid}, 8'd0);

        // In S_INT a lone fetch is ignored
        fetch = 1'b1; data_bus_in = 8'h55;
        tick();
        check_all("sint_fetch_ignored", 8'h00, 1'b0, 1'b1, 1'b1, 2'b10);
        fetch = 1'b0;

        int_done = 1'b1;
        tick();
        check_all("int_done", 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
        int_done = 1'b0;

        // Normal fetch
        fetch = 1'b1; data_bus_in = 8'h0A;
        tick();
        check_all("normal_0A", 8'h0A, 1'b1, 1'b0, 1'b0, 2'b00);
        fetch = 1'b0;
        tick();
        check("normal_valid_drop", {7'd0, opcode_valid}, 8'd0);

        // IRQ taken
        irq = 1'b0; i_flag = 1'b0; fetch = 1'b1; data_bus_in = 8'h06;
        tick();
        check_all("irq_brk", 8'h00, 1'b1, 1'b1, 1'b1, 2'b11);
        fetch = 1'b0; irq = 1'b1; int_done = 1'b1;
        tick();
        int_done = 1'b0;

        // IRQ masked by i_flag
        irq = 1'b0; i_flag = 1'b1; fetch = 1'b1; data_bus_in = 8'h06;
        tick();
        check_all("irq_masked", 8'h06, 1'b1, 1'b0, 1'b0, 2'b00);
        fetch = 1'b0;

        // NMI 3 clocks before fetch beats a simultaneous IRQ
        i_flag = 1'b0; nmi = 1'b0;
        tick(); tick(); tick();
        fetch = 1'b1; data_bus_in = 8'h11;
        tick();
        check_all("nmi_over_irq", 8'h00, 1'b1, 1'b1, 1'b1, 2'b01);
        fetch = 1'b0; nmi = 1'b1; int_done = 1'b1;
        tick();
        int_done = 1'b0;
        // Pending was cleared, so the IRQ is next
        fetch = 1'b1;
        tick();
        check_all("irq_after_nmi", 8'h00, 1'b1, 1'b1, 1'b1, 2'b11);
        fetch = 1'b0; irq = 1'b1; int_done = 1'b1;
        tick();
        int_done = 1'b0;
        tick();

        // NMI edge on the fetch clock waits for the following fetch
        nmi = 1'b0; fetch = 1'b1; data_bus_in = 8'h0A;
        tick();
        check_all("nmi_same_clk", 8'h0A, 1'b1, 1'b0, 1'b0, 2'b00);
        fetch = 1'b0; nmi = 1'b1;
        tick();
        fetch = 1'b1; data_bus_in = 8'h0B;
        tick();
        check_all("nmi_next_fetch", 8'h00, 1'b1, 1'b1, 1'b1, 2'b01);
        fetch = 1'b0; int_done = 1'b1;
        tick();
        int_done = 1'b0;

        fetch = 1'b1; data_bus_in = 8'h22;
        tick();
        check("pre_rdy_load", instruction, 8'h22);

        // rdy low: freeze, but keep capturing the NMI edge
        rdy = 1'b0; data_bus_in = 8'h33; nmi = 1'b0;
        tick();
        check_all("rdy_low_1", 8'h22, 1'b0, 1'b0, 1'b0, 2'b00);
        nmi = 1'b1;
        tick(); tick();
        tick();
        check_all("rdy_low_4", 8'h22, 1'b0, 1'b0, 1'b0, 2'b00);
        rdy = 1'b1;
        tick();
        check_all("rdy_high_nmi", 8'h00, 1'b1, 1'b1, 1'b1, 2'b01);

        // int_done and fetch on the same clock
        int_done = 1'b1; data_bus_in = 8'h0A;
        tick();
        check_all("done_and_fetch", 8'h0A, 1'b1, 1'b0, 1'b0, 2'b00);
        int_done = 1'b0; fetch = 1'b0;

        // Enter S_INT via IRQ, leave an NMI pending, then reset mid-sequence
        irq = 1'b0; fetch = 1'b1;
        tick();
        check_all("irq_again", 8'h00, 1'b1, 1'b1, 1'b1, 2'b11);
        fetch = 1'b0; irq = 1'b1; nmi = 1'b0;
        tick();
        nmi = 1'b1;
        tick();
        #2 res = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 1'b0, 1'b1, 1'b0, 2'b10);
        tick();
        res = 1'b1;
        tick();
        fetch = 1'b1;
        tick();
        check_all("post_reset_brk", 8'h00, 1'b1, 1'b1, 1'b1, 2'b10);
        fetch = 1'b0; int_done = 1'b1;
        tick();
        int_done = 1'b0;
        // Pending NMI was lost in the reset
        fetch = 1'b1; data_bus_in = 8'h44;
        tick();
        check_all("nmi_lost", 8'h44, 1'b1, 1'b0, 1'b0, 2'b00);
        fetch = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
